dmem_lsu: RTL

Load/store unit plus data memory that sits directly downstream of the single-cycle RISC-V datapath. It consumes the datapath's memory address, store data, and funct3. It returns ReadData, sign- or zero-extended per the load type. It models a multi-cycle memory: it stalls the core (PC and register write held) for a programmable number of wait states, then completes the access in one response cycle.

---
 rtl/dmem_lsu_if.sv | 23 ++
 rtl/dmem_lsu.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_if.sv
// Core-to-LSU memory bus: request fields driven by the core, response and stall
// returned by the load/store unit.
interface dmem_lsu_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        misalign;

  modport master (
    output req, we, funct3, addr, wdata,
    input  rdata, stall, done, misalign
  );

  modport slave (
    input  req, we, funct3, addr, wdata,
    output rdata, stall, done, misalign
  );
endinterface

// File: rtl/dmem_lsu.sv
// Multi-cycle load/store unit with internal word RAM (IDLE -> BUSY -> RESP).
// Optional MISALIGN_TRAP_EN: misaligned accesses are flagged and suppressed instead of force-aligned.
module dmem_lsu #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic     clk,
  input  logic     reset,
  dmem_lsu_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [31:0]    rdata_q;
  logic           done_q;
  logic           misalign_q;
  logic [31:0]    mem_q [DEPTH];

  logic           commit_s;
  logic           op_we_s;
  logic [2:0]     op_f3_s;
  logic [AW+1:0]  op_addr_s;
  logic [31:0]    op_wdata_s;
  logic [AW+1:0]  eff_addr_s;
  logic           trap_s;
  logic [AW-1:0]  idx_s;
  logic [3:0]     be_s;
  logic [31:0]    wd_s;
  logic [31:0]    ld_s;
  logic           unused_addr_s;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                              input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b010:  load_extend = word;
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  store_mask = 4'b0001 << a;
      3'b001:  store_mask = a[1] ? 4'b1100 : 4'b0011;
      3'b010:  store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  store_data = {4{wd[7:0]}};
      3'b001:  store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic half;
    logic word;
    half = (f3 == 3'b001) || (!we && (f3 == 3'b101));
    word = (f3 == 3'b010);
    is_misaligned = (half && a[0]) || (word && (a != 2'b00));
  endfunction
`else
  function automatic logic [AW+1:0] align_addr(input logic [2:0] f3, input logic [AW+1:0] a);
    case (f3[1:0])
      2'b01:   align_addr = {a[AW+1:1], 1'b0};
      2'b10:   align_addr = {a[AW+1:2], 2'b00};
      default: align_addr = a;
    endcase
  endfunction
`endif

  assign unused_addr_s = ^bus.addr[31:AW+2];

  // Operand select and commit datapath; with no wait states the access commits straight from IDLE
  always_comb begin
    op_we_s    = we_q;
    op_f3_s    = f3_q;
    op_addr_s  = addr_q;
    op_wdata_s = wdata_q;
    if (state_q == ST_IDLE) begin
      op_we_s    = bus.we;
      op_f3_s    = bus.funct3;
      op_addr_s  = bus.addr[AW+1:0];
      op_wdata_s = bus.wdata;
    end else begin
      op_we_s    = we_q;
      op_f3_s    = f3_q;
      op_addr_s  = addr_q;
      op_wdata_s = wdata_q;
    end

    commit_s = reset && (((state_q == ST_IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                         ((state_q == ST_BUSY) && (cnt_q == 4'd1)));

`ifdef MISALIGN_TRAP_EN
    eff_addr_s = op_addr_s;
    trap_s     = is_misaligned(op_we_s, op_f3_s, op_addr_s[1:0]);
`else
    eff_addr_s = align_addr(op_f3_s, op_addr_s);
    trap_s     = 1'b0;
`endif

    idx_s = eff_addr_s[AW+1:2];
    wd_s  = store_data(op_f3_s, op_wdata_s);
    if (op_we_s && !trap_s) begin
      be_s = store_mask(op_f3_s, eff_addr_s[1:0]);
    end else begin
      be_s = 4'b0000;
    end
    if (trap_s) begin
      ld_s = 32'd0;
    end else begin
      ld_s = load_extend(op_f3_s, mem_q[idx_s], eff_addr_s[1:0]);
    end
  end

  // RAM byte-lane writes on the edge entering RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (commit_s) begin
      for (int l = 0; l < 4; l++) begin
        if (be_s[l]) begin
          mem_q[idx_s][8*l +: 8] <= wd_s[8*l +: 8];
        end
      end
    end
  end

  // Access sequencing FSM with registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      rdata_q    <= 32'd0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr[AW+1:0];
            wdata_q <= bus.wdata;
            we_q    <= bus.we;
            f3_q    <= bus.funct3;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES > 0) ? ST_BUSY : ST_RESP;
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (commit_s) begin
        done_q     <= 1'b1;
        misalign_q <= trap_s;
        if (!op_we_s) begin
          rdata_q <= ld_s;
        end
      end
    end
  end

  assign bus.stall    = reset && ((state_q == ST_IDLE) ? bus.req : (state_q == ST_BUSY));
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.misalign = misalign_q;

endmodule
